// File: rtl/count_checker_pkg.sv
// count_checker shared types: lane states, pattern modes
// and the expected-value step function.
package count_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEED    = 2'd1,
    S_ACQUIRE = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_INCR  = 2'b00;
  localparam logic [1:0] MODE_DECR  = 2'b01;
  localparam logic [1:0] MODE_FIXED = 2'b10;

  // Wide enough for any supported lane width; callers truncate
  localparam int VAL_W = 64;

  function automatic logic [VAL_W-1:0] next_value(
    input logic [VAL_W-1:0] x,
    input logic [1:0]       mode
  );
    case (mode)
      MODE_DECR:  return x - 64'd1;
      MODE_FIXED: return x;
      default:    return x + 64'd1;
    endcase
  endfunction

endpackage

// File: rtl/count_checker_mc_if.sv
// Rx user-interface bundle feeding the multi-lane checker.
interface count_checker_mc_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 32
);
  logic [NUM_LANES-1:0]        valid_i;
  logic [NUM_LANES*DATA_W-1:0] data_i;
  logic [NUM_LANES-1:0]        crc_err_i;

  modport master (
    output valid_i,
    output data_i,
    output crc_err_i
  );

  modport slave (
    input valid_i,
    input data_i,
    input crc_err_i
  );
endinterface

// File: rtl/count_checker_lane.sv
// One lane: seed/acquire/lock FSM, pattern compare and
// saturating mismatch / CRC counters.
module count_checker_lane
  import count_checker_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16,
  parameter int CRC_THRESH = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [1:0]        mode_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              crc_err_i,
  output logic              lock_o,
  output logic              error_o,
  output logic              crc_error_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  crc_cnt_o,
  output logic [DATA_W-1:0] expected_o
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_CNT - 1);
  localparam logic [CNT_W-1:0]  THRESH    = CNT_W'(CRC_THRESH);

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [CNT_W-1:0]    crc_q, crc_d;
  logic                errf_q, errf_d;
  logic                crcf_q, crcf_d;
  logic                match;
  logic                err_inc;
  logic                crc_inc;

  function automatic logic [DATA_W-1:0] step(
    input logic [DATA_W-1:0] x,
    input logic [1:0]        m
  );
    return DATA_W'(next_value(VAL_W'(x), m));
  endfunction

  assign match = (data_i == exp_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    exp_d   = exp_q;
    run_d   = run_q;
    miss_d  = miss_q;
    errf_d  = errf_q;
    err_inc = 1'b0;
    crc_inc = valid_i && crc_err_i && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        state_d = S_SEED;
        mode_d  = mode_i;
      end
      S_SEED: begin
        if (valid_i) begin
          exp_d   = step(data_i, mode_q);
          run_d   = '0;
          state_d = S_ACQUIRE;
        end
      end
      S_ACQUIRE: begin
        if (valid_i && match) begin
          exp_d = step(exp_q, mode_q);
          if (run_q == RUN_LAST) begin
            state_d = S_LOCKED;
            run_d   = '0;
            miss_d  = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end else if (valid_i) begin
          exp_d = step(data_i, mode_q);
          run_d = '0;
        end
      end
      S_LOCKED: begin
        if (valid_i && match) begin
          exp_d  = step(exp_q, mode_q);
          miss_d = '0;
        end else if (valid_i) begin
          err_inc = 1'b1;
          errf_d  = 1'b1;
          if (miss_q == MISS_LAST) begin
            state_d = S_ACQUIRE;
            exp_d   = step(data_i, mode_q);
            run_d   = '0;
            miss_d  = '0;
          end else begin
            exp_d  = step(exp_q, mode_q);
            miss_d = miss_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_d = (err_inc && err_q != '1) ? err_q + 1'b1 : err_q;
    crc_d = (crc_inc && crc_q != '1) ? crc_q + 1'b1 : crc_q;

    if (clear_i) begin
      err_d  = '0;
      crc_d  = '0;
      errf_d = 1'b0;
    end

    crcf_d = (crc_d >= THRESH);

    // Dropping start is a soft reset of the whole lane
    if (!start_i) begin
      state_d = S_IDLE;
      mode_d  = '0;
      exp_d   = '0;
      run_d   = '0;
      miss_d  = '0;
      err_d   = '0;
      crc_d   = '0;
      errf_d  = 1'b0;
      crcf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      exp_q   <= '0;
      run_q   <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      crc_q   <= '0;
      errf_q  <= 1'b0;
      crcf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      exp_q   <= exp_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      crc_q   <= crc_d;
      errf_q  <= errf_d;
      crcf_q  <= crcf_d;
    end
  end

  assign lock_o      = (state_q == S_LOCKED);
  assign error_o     = errf_q;
  assign crc_error_o = crcf_q;
  assign err_cnt_o   = err_q;
  assign crc_cnt_o   = crc_q;
  assign expected_o  = exp_q;

endmodule

// File: rtl/count_checker_mc.sv
// Multi-lane Rx count checker: NUM_LANES independent lanes
// sharing start, clear and pattern mode.
module count_checker_mc
  import count_checker_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_LANES  = 4,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16,
  parameter int CRC_THRESH = 3
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        clear_i,
  input  logic [1:0]                  mode_i,
  count_checker_mc_if.slave           rx,
  output logic [NUM_LANES-1:0]        lock_o,
  output logic [NUM_LANES-1:0]        error_o,
  output logic [NUM_LANES-1:0]        crc_error_o,
  output logic [NUM_LANES*CNT_W-1:0]  err_cnt_o,
  output logic [NUM_LANES*CNT_W-1:0]  crc_cnt_o,
  output logic [NUM_LANES*DATA_W-1:0] expected_o
);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    count_checker_lane #(
      .DATA_W     (DATA_W),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_CNT (UNLOCK_CNT),
      .CNT_W      (CNT_W),
      .CRC_THRESH (CRC_THRESH)
    ) u_lane (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .start_i     (start_i),
      .clear_i     (clear_i),
      .mode_i      (mode_i),
      .valid_i     (rx.valid_i[k]),
      .data_i      (rx.data_i[k*DATA_W +: DATA_W]),
      .crc_err_i   (rx.crc_err_i[k]),
      .lock_o      (lock_o[k]),
      .error_o     (error_o[k]),
      .crc_error_o (crc_error_o[k]),
      .err_cnt_o   (err_cnt_o[k*CNT_W +: CNT_W]),
      .crc_cnt_o   (crc_cnt_o[k*CNT_W +: CNT_W]),
      .expected_o  (expected_o[k*DATA_W +: DATA_W])
    );
  end

endmodule
